key_round_ctrl: RTL and testbench
=================================

// Module: key_round_ctrl
// PURPOSE
//  Sequencer between Key_scheduler and the cipher round datapath. On start it steps the
//  scheduler once per round via ks_en and captures its three registered 8-bit subkeys.
//  It then hands each subkey triple to the round datapath over a valid/ready handshake.
//  Runs NUM_ROUNDS rounds per session, then pulses done.
// PARAMETERS
//  NUM_ROUNDS  16  rounds per session; legal range 1..2^ROUND_W
//  ROUND_W     5   width of rk_round; must satisfy 2^ROUND_W >= NUM_ROUNDS
//  KEY_W       8   subkey width; must match Key_scheduler outputs
// PORTS
//  CLK       in   1        single clock, rising edge
//  RST_N     in   1        asynchronous, active-low reset
//  start     in   1        begin a session; sampled in IDLE only
//  abort     in   1        cancel session; highest priority
//  busy      out  1        high in any state other than IDLE
//  done      out  1        1-cycle pulse after the last round is accepted
//  ks_en     out  1        enable to Key_scheduler; high exactly 1 cycle per round
//  ks_k1     in   KEY_W    Key_scheduler K_1
//  ks_k2     in   KEY_W    Key_scheduler K_2
//  ks_k3     in   KEY_W    Key_scheduler K_3
//  rk_valid  out  1        subkey triple valid to the datapath
//  rk_ready  in   1        datapath accepts the triple
//  rk_k1     out  KEY_W    captured subkey 1
//  rk_k2     out  KEY_W    captured subkey 2
//  rk_k3     out  KEY_W    captured subkey 3
//  rk_round  out  ROUND_W  round index 0..NUM_ROUNDS-1 of the presented triple
//  rk_last   out  1        high with rk_valid when rk_round == NUM_ROUNDS-1
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE, round=0. All outputs 0, including rk_k*, rk_round and done.
//  FSM, one step per edge:
//   IDLE: start=1 -> STEP (round=0).
//   STEP: ks_en=1 -> WAIT. Key_scheduler registers its new subkeys at this edge.
//   WAIT: ks_k* are now valid; at this edge capture ks_k1..ks_k3 into rk_k1..rk_k3 -> PRESENT.
//   PRESENT: rk_valid=1.
//    - rk_ready=1 and round==NUM_ROUNDS-1 -> DONE.
//    - rk_ready=1 otherwise -> round+1, go to STEP.
//    - rk_ready=0 -> stay; rk_valid and all rk_* held stable.
//   DONE: done=1 for this cycle only -> IDLE.
//  Latency: start sampled at edge E0 -> ks_en high during E0..E1 -> rk_valid high after E2.
//   With rk_ready tied high, one round completes every 3 cycles.
//   A session takes 3*NUM_ROUNDS+1 cycles from start to done.
//  Handshake: a transfer occurs only when rk_valid & rk_ready at an edge. rk_valid never drops
//   without a transfer, except on abort or reset. rk_ready while rk_valid=0 is ignored.
//  rk_valid=0 outside PRESENT. rk_k* and rk_round keep their last values (not cleared)
//   after a transfer.
//  Boundaries:
//   - start outside IDLE (including the DONE cycle) is ignored. No queuing.
//   - abort=1 in any state -> IDLE at the next edge. round=0; rk_valid, ks_en and busy
//     return to 0; no done pulse.
//   - abort and start together in IDLE: abort wins; stay in IDLE.
//   - abort in STEP still lets that cycle's ks_en reach Key_scheduler.
//   - Key_scheduler has no rewind. After an abort the next session continues the
//     scheduler's count; the controller does not compensate.
//   - NUM_ROUNDS=1: the first triple has rk_last=1; the session ends after one transfer.
//   - round counter never wraps: it is ROUND_W wide and stops at NUM_ROUNDS-1.
//   - Reset mid-session: async return to the reset state. An in-flight ks_en is deasserted
//     immediately.
// STRUCTURE
//  crypt_pkg: KEY_W constant and the state type {IDLE, STEP, WAIT, PRESENT, DONE} with
//   fixed 3-bit encoding; shared with the datapath controller.
//  One sub-module, key_round_reg: 3xKEY_W + ROUND_W capture/hold register with a load
//   enable and async RST_N clear. It is instantiated once.
//  The top holds the FSM and round counter only. Key_scheduler is instantiated by the
//   parent, not here.
// TESTING (bench instantiates Key_scheduler with its default key, connected to this block)
//  1. Reset, then start pulse with rk_ready=1 and NUM_ROUNDS=16 ->
//     - ks_en pulses 16 times, 3 cycles apart;
//     - round 0 triple = {A1^01, B2^02, F3^03} = {A0, B0, F0};
//     - done fires exactly once, 49 cycles after start.
//  2. rk_ready=0 for 5 cycles in round 2 -> rk_valid stays high, rk_k*/rk_round=2 stable,
//     no extra ks_en; resumes on ready.
//  3. abort asserted in WAIT of round 3 -> next edge IDLE, busy=0, rk_valid=0, no done;
//     a new start proceeds normally.
//  4. start held high through a whole session -> exactly one session per IDLE visit;
//     the start seen in the DONE cycle is ignored.
//  5. start and abort in the same IDLE cycle -> stays IDLE, ks_en never asserted.
//  6. RST_N low while in PRESENT -> all outputs 0 immediately (async), ks_en=0;
//     NUM_ROUNDS=1 build: rk_last=1 on the first triple.

Source files
------------

// File: rtl/key_round_ctrl_pkg.sv
// key_round_ctrl_pkg
//   Shared constants and types for the key/round sequencer and its datapath peers.
//   KEY_W   : subkey width produced by the key scheduler
//   state_t : sequencer state, fixed 3-bit encoding so other controllers can decode it
package key_round_ctrl_pkg;

    localparam int KEY_W = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STEP    = 3'd1,
        WAIT    = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/key_round_ctrl_if.sv
// key_round_ctrl_if
//   Round-key handshake from the sequencer to the cipher round datapath.
//   rk_valid/rk_ready : valid/ready handshake, transfer on valid & ready at an edge
//   rk_k1..rk_k3      : captured subkey triple
//   rk_round          : round index of the presented triple
//   rk_last           : presented triple belongs to the final round
//   master = sequencer side, slave = datapath side
interface key_round_ctrl_if #(
    parameter int KEY_W   = key_round_ctrl_pkg::KEY_W,
    parameter int ROUND_W = 5
);
    logic               rk_valid;
    logic               rk_ready;
    logic [KEY_W-1:0]   rk_k1;
    logic [KEY_W-1:0]   rk_k2;
    logic [KEY_W-1:0]   rk_k3;
    logic [ROUND_W-1:0] rk_round;
    logic               rk_last;

    modport master (
        output rk_valid, rk_k1, rk_k2, rk_k3, rk_round, rk_last,
        input  rk_ready
    );

    modport slave (
        input  rk_valid, rk_k1, rk_k2, rk_k3, rk_round, rk_last,
        output rk_ready
    );
endinterface

// File: rtl/key_round_ctrl_reg.sv
// key_round_reg
//   Capture/hold register for one subkey triple plus its round index.
//   CLK, RST_N          : clock, async active-low clear
//   load                : capture d_* at the edge
//   d_k1..d_k3, d_round : values to capture
//   q_k1..q_k3, q_round : held values (kept until the next load)
module key_round_reg #(
    parameter int KEY_W   = 8,
    parameter int ROUND_W = 5
) (
    input  logic               CLK,
    input  logic               RST_N,
    input  logic               load,
    input  logic [KEY_W-1:0]   d_k1,
    input  logic [KEY_W-1:0]   d_k2,
    input  logic [KEY_W-1:0]   d_k3,
    input  logic [ROUND_W-1:0] d_round,
    output logic [KEY_W-1:0]   q_k1,
    output logic [KEY_W-1:0]   q_k2,
    output logic [KEY_W-1:0]   q_k3,
    output logic [ROUND_W-1:0] q_round
);
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_k1    <= '0;
            q_k2    <= '0;
            q_k3    <= '0;
            q_round <= '0;
        end else if (load) begin
            q_k1    <= d_k1;
            q_k2    <= d_k2;
            q_k3    <= d_k3;
            q_round <= d_round;
        end
    end
endmodule

// File: rtl/key_round_ctrl.sv
// key_round_ctrl
//   Steps an external key scheduler once per round, captures its three subkeys and
//   presents them to the round datapath over valid/ready. NUM_ROUNDS rounds per
//   session, then a one-cycle done pulse.
//   CLK, RST_N         : clock, async active-low reset
//   start, abort       : session control (abort wins over everything)
//   busy, done         : status; done pulses once after the last transfer
//   ks_en              : scheduler step enable, one cycle per round
//   ks_k1..ks_k3       : scheduler subkeys, valid the cycle after ks_en
//   rk                 : round-key handshake (master side)
module key_round_ctrl #(
    parameter int NUM_ROUNDS = 16,
    parameter int ROUND_W    = 5,
    parameter int KEY_W      = key_round_ctrl_pkg::KEY_W
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 ks_en,
    input  logic [KEY_W-1:0]     ks_k1,
    input  logic [KEY_W-1:0]     ks_k2,
    input  logic [KEY_W-1:0]     ks_k3,
    key_round_ctrl_if.master     rk
);
    import key_round_ctrl_pkg::*;

    localparam logic [ROUND_W-1:0] LAST_RND = ROUND_W'(NUM_ROUNDS - 1);

    state_t             state;
    logic [ROUND_W-1:0] round;
    logic               valid_q;
    logic               last_q;
    logic               load;

    // Scheduler outputs settle one edge after ks_en; capture them on the WAIT edge
    // unless the session is being cancelled.
    assign load        = (state == WAIT) && !abort;
    assign rk.rk_valid = valid_q;
    assign rk.rk_last  = last_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= IDLE;
            round   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ks_en   <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state   <= IDLE;
                round   <= '0;
                busy    <= 1'b0;
                ks_en   <= 1'b0;
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        state <= STEP;
                        round <= '0;
                        busy  <= 1'b1;
                        ks_en <= 1'b1;
                    end
                    STEP: begin
                        state <= WAIT;
                        ks_en <= 1'b0;
                    end
                    WAIT: begin
                        state   <= PRESENT;
                        valid_q <= 1'b1;
                        last_q  <= (round == LAST_RND);
                    end
                    PRESENT: if (rk.rk_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (round == LAST_RND) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // counter stops at LAST_RND, so it can never wrap
                            round <= round + ROUND_W'(1);
                            state <= STEP;
                            ks_en <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        round <= '0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    key_round_reg #(.KEY_W(KEY_W), .ROUND_W(ROUND_W)) u_reg (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .load    (load),
        .d_k1    (ks_k1),
        .d_k2    (ks_k2),
        .d_k3    (ks_k3),
        .d_round (round),
        .q_k1    (rk.rk_k1),
        .q_k2    (rk.rk_k2),
        .q_k3    (rk.rk_k3),
        .q_round (rk.rk_round)
    );
endmodule

// File: tb/tb_key_round_ctrl.sv
module tb_key_round_ctrl;
    localparam int NR = 16;

    logic CLK = 1'b0;
    logic RST_N = 1'b1;
    logic start = 1'b0, abort = 1'b0;
    logic busy, done, ks_en;
    logic [7:0] ks_k1, ks_k2, ks_k3;

    logic start1 = 1'b0;
    logic busy1, done1, ks_en1;
    logic [7:0] k1_1, k2_1, k3_1;

    key_round_ctrl_if #(.KEY_W(8), .ROUND_W(5)) rk ();
    key_round_ctrl_if #(.KEY_W(8), .ROUND_W(1)) rk1 ();

    always #5 CLK = ~CLK;

    // Stand-in key scheduler: counts its enables; subkeys are the default key XOR the count.
    logic [7:0] sch_cnt = 8'd0, sch_cnt1 = 8'd0;
    always_ff @(posedge CLK) if (ks_en)  sch_cnt  <= sch_cnt + 8'd1;
    always_ff @(posedge CLK) if (ks_en1) sch_cnt1 <= sch_cnt1 + 8'd1;
    assign ks_k1 = 8'hA1 ^ sch_cnt;
    assign ks_k2 = 8'hB2 ^ (sch_cnt + 8'd1);
    assign ks_k3 = 8'hF3 ^ (sch_cnt + 8'd2);
    assign k1_1  = 8'hA1 ^ sch_cnt1;
    assign k2_1  = 8'hB2 ^ (sch_cnt1 + 8'd1);
    assign k3_1  = 8'hF3 ^ (sch_cnt1 + 8'd2);

    key_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_W(5), .KEY_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort),
        .busy(busy), .done(done), .ks_en(ks_en),
        .ks_k1(ks_k1), .ks_k2(ks_k2), .ks_k3(ks_k3), .rk(rk.master)
    );

    key_round_ctrl #(.NUM_ROUNDS(1), .ROUND_W(1), .KEY_W(8)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .start(start1), .abort(1'b0),
        .busy(busy1), .done(done1), .ks_en(ks_en1),
        .ks_k1(k1_1), .ks_k2(k2_1), .ks_k3(k3_1), .rk(rk1.master)
    );

    // Edge-level event counters (values seen by the clock edge).
    int cyc = 0, ks_cnt = 0, done_cnt = 0;
    always @(posedge CLK) begin
        cyc++;
        if (ks_en) ks_cnt++;
        if (done)  done_cnt++;
    end

    int n_pass = 0, n_chk = 0;
    int sch_base = 0;   // scheduler steps taken before the current session

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge CLK); #1;
    endtask

    // Expected triple once the scheduler has taken c steps in total.
    function automatic logic [23:0] exp_keys(input int c);
        logic [7:0] b;
        b = 8'(c);
        return {8'hA1 ^ b, 8'hB2 ^ (b + 8'd1), 8'hF3 ^ (b + 8'd2)};
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_valid"}, rk.rk_valid, 0);
        chk({tag, "_ksen"},  ks_en, 0);
        chk({tag, "_done"},  done, 0);
    endtask

    task automatic session(input int stall_rnd, input int stall_len, input bit rnd_rdy,
                           input int abort_rnd, input bit hold_start);
        int w, s, stalls, t0, ks0, dn0;
        logic [23:0] ek;
        t0 = cyc; ks0 = ks_cnt; dn0 = done_cnt; stalls = 0;
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        for (int r = 0; r < NR; r++) begin
            w = 0;
            chk("ks_en_step", ks_en, 1);
            while (!rk.rk_valid && w < 10) begin
                if (r == abort_rnd && w == 1) begin
                    abort = 1'b1;
                    tick();
                    abort = 1'b0;
                    chk_idle("abort");
                    tick(); tick();
                    chk("abort_nodone", done_cnt - dn0, 0);
                    sch_base += r + 1;
                    return;
                end
                rk.rk_ready = rnd_rdy ? 1'($urandom) : 1'b1;
                tick();
                w++;
            end
            chk("latency", w, 2);
            ek = exp_keys(sch_base + r + 1);
            if (sch_base == 0 && r == 0)
                chk("r0_triple", {rk.rk_k1, rk.rk_k2, rk.rk_k3}, 24'hA0B0F0);
            chk("triple", {rk.rk_k1, rk.rk_k2, rk.rk_k3}, ek);
            chk("round", rk.rk_round, r);
            chk("last", rk.rk_last, (r == NR - 1));
            s = (r == stall_rnd) ? stall_len : (rnd_rdy ? int'($urandom_range(0, 3)) : 0);
            for (int i = 0; i < s; i++) begin
                rk.rk_ready = 1'b0;
                tick();
                chk("stall_valid", rk.rk_valid, 1);
                chk("stall_triple", {rk.rk_k1, rk.rk_k2, rk.rk_k3}, ek);
                chk("stall_round", rk.rk_round, r);
                chk("stall_ksen", ks_en, 0);
            end
            stalls += s;
            rk.rk_ready = 1'b1;
            tick();
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_valid", rk.rk_valid, 0);
        chk("sess_len", cyc - t0, 3 * NR + 1 + stalls);
        tick();
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("ks_pulses", ks_cnt - ks0, NR);
        chk("done_once", done_cnt - dn0, 1);
        sch_base += NR;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ks0;
        rk.rk_ready = 1'b1;
        rk1.rk_ready = 1'b1;
        // reset state
        #1 RST_N = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst_triple", {rk.rk_k1, rk.rk_k2, rk.rk_k3}, 0);
        chk("rst_round", rk.rk_round, 0);
        chk("rst_last", rk.rk_last, 0);
        #20 RST_N = 1'b1;
        tick();

        // 1: nominal session, ready tied high
        session(-1, 0, 1'b0, -1, 1'b0);
        // 2: 5-cycle stall in round 2
        session(2, 5, 1'b0, -1, 1'b0);
        // 3: abort in WAIT of round 3, then a fresh session with random ready
        session(-1, 0, 1'b0, 3, 1'b0);
        session(-1, 0, 1'b1, -1, 1'b0);
        // 4: start held high; DONE-cycle start ignored, next IDLE start accepted
        session(-1, 0, 1'b0, -1, 1'b1);
        tick();
        chk("hold_restart_busy", busy, 1);
        chk("hold_restart_ksen", ks_en, 1);
        start = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        sch_base += 1;
        chk_idle("hold_abort");
        // 5: start and abort together in IDLE
        ks0 = ks_cnt;
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_idle("sa");
        tick(); tick();
        chk("sa_noks", ks_cnt - ks0, 0);
        // 6: async reset while PRESENT, then while STEP
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        chk("pre_rst_valid", rk.rk_valid, 1);
        sch_base += 1;
        RST_N = 1'b0; #1;
        chk_idle("arst");
        chk("arst_triple", {rk.rk_k1, rk.rk_k2, rk.rk_k3}, 0);
        chk("arst_round", rk.rk_round, 0);
        #3 RST_N = 1'b1;
        tick();
        start = 1'b1; tick(); start = 1'b0;
        chk("step_ksen", ks_en, 1);
        RST_N = 1'b0; #1;
        chk("arst_ksen", ks_en, 0);
        #3 RST_N = 1'b1;
        tick();
        // NUM_ROUNDS=1 build
        start1 = 1'b1; tick(); start1 = 1'b0;
        tick(); tick();
        chk("nr1_valid", rk1.rk_valid, 1);
        chk("nr1_last", rk1.rk_last, 1);
        chk("nr1_round", rk1.rk_round, 0);
        chk("nr1_triple", {rk1.rk_k1, rk1.rk_k2, rk1.rk_k3}, 24'hA0B0F0);
        tick();
        chk("nr1_done", done1, 1);
        tick();
        chk("nr1_idle", busy1, 0);
        // scheduler count carries over across abort/reset; final random session
        session(-1, 0, 1'b1, -1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
